// File: rtl/trig_pkg.sv
// Shared trigger configuration definitions for the channel trigger qualifier.
package trig_pkg;

  localparam int unsigned TRIG_CFG_W     = 5;
  localparam int unsigned TRIG_LOW_LVL   = 4;
  localparam int unsigned TRIG_HIGH_LVL  = 3;
  localparam int unsigned TRIG_NEG_EDGE  = 2;
  localparam int unsigned TRIG_POS_EDGE  = 1;
  localparam int unsigned TRIG_DONT_CARE = 0;

  typedef logic [TRIG_CFG_W-1:0] trig_cfg_t;

endpackage

// File: rtl/trig_edge_capture.sv
// Edge detector with a sticky, arm-gated capture flag for one comparator input.
module trig_edge_capture #(
  parameter bit FALLING = 1'b0,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic armed_i,
  input  logic sig_i,
  output logic seen_nxt_c_o
);

  logic hist_q;
  logic seen_q;
  logic seen_d;
  logic evt_c;

  // Edge event and next sticky flag; disarm clears even a coincident edge.
  always_comb begin
    evt_c  = 1'b0;
    seen_d = 1'b0;
    if (FALLING) begin
      evt_c = ~sig_i & hist_q;
    end else begin
      evt_c = sig_i & ~hist_q;
    end
    if (armed_i) begin
      seen_d = seen_q | evt_c;
    end
  end

  // History sample and sticky flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= RST_VAL;
      seen_q <= 1'b0;
    end else begin
      hist_q <= sig_i;
      seen_q <= seen_d;
    end
  end

  assign seen_nxt_c_o = seen_d;

endmodule

// File: rtl/channel_trigger_logic.sv
// Per-channel trigger qualifier: ORs level, armed-edge and force conditions into one registered flag.
module channel_trigger_logic
  import trig_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_armed,
  input  logic                  CHxHff5,
  input  logic                  CHxLff5,
  input  logic [TRIG_CFG_W-1:0] CHxTrigCfg,
  output logic                  ChxTrig
);

  trig_cfg_t cfg_c;
  logic      pos_nxt_c;
  logic      neg_nxt_c;
  logic      trig_d;
  logic      trig_q;

  assign cfg_c = trig_cfg_t'(CHxTrigCfg);

  // Rising edge of the high comparator.
  trig_edge_capture #(
    .FALLING (1'b0),
    .RST_VAL (1'b0)
  ) u_pos_capture (
    .clk          (clk),
    .rst_n        (rst_n),
    .armed_i      (set_armed),
    .sig_i        (CHxHff5),
    .seen_nxt_c_o (pos_nxt_c)
  );

  // Falling edge of the low comparator (idle high).
  trig_edge_capture #(
    .FALLING (1'b1),
    .RST_VAL (1'b1)
  ) u_neg_capture (
    .clk          (clk),
    .rst_n        (rst_n),
    .armed_i      (set_armed),
    .sig_i        (CHxLff5),
    .seen_nxt_c_o (neg_nxt_c)
  );

  // Combine enabled conditions; edge terms use next-state flags for same-clock reporting.
  always_comb begin
    trig_d = 1'b0;
    trig_d = cfg_c[TRIG_DONT_CARE]
           | (cfg_c[TRIG_POS_EDGE] & pos_nxt_c)
           | (cfg_c[TRIG_NEG_EDGE] & neg_nxt_c)
           | (cfg_c[TRIG_HIGH_LVL] & CHxHff5)
           | (cfg_c[TRIG_LOW_LVL]  & ~CHxLff5);
  end

  // Registered trigger output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q <= 1'b0;
    end else begin
      trig_q <= trig_d;
    end
  end

  assign ChxTrig = trig_q;

endmodule

// File: tb/tb_channel_trigger_logic.sv
// Directed bench for channel_trigger_logic with a reference model for the long mixed run.
module tb_channel_trigger_logic;

  logic       clk;
  logic       rst_n;
  logic       set_armed;
  logic       h;
  logic       l;
  logic [4:0] cfg;
  logic       trig;

  int n_cmp;
  int n_err;

  channel_trigger_logic dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_armed  (set_armed),
    .CHxHff5    (h),
    .CHxLff5    (l),
    .CHxTrigCfg (cfg),
    .ChxTrig    (trig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written directly from the behavioural description.
  logic m_hp, m_lp, m_pos, m_neg, m_trig;
  logic m_pos_n, m_neg_n;
  always_comb begin
    m_pos_n = set_armed ? (m_pos | (h & ~m_hp)) : 1'b0;
    m_neg_n = set_armed ? (m_neg | (~l & m_lp)) : 1'b0;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hp <= 1'b0; m_lp <= 1'b1; m_pos <= 1'b0; m_neg <= 1'b0; m_trig <= 1'b0;
    end else begin
      m_hp  <= h;
      m_lp  <= l;
      m_pos <= m_pos_n;
      m_neg <= m_neg_n;
      m_trig <= cfg[0] | (cfg[1] & m_pos_n) | (cfg[2] & m_neg_n) | (cfg[3] & h) | (cfg[4] & ~l);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0; set_armed = 1'b0; h = 1'b0; l = 1'b1; cfg = 5'b00000;

    // 1. Reset holds output low while inputs toggle; force asserts after release.
    for (int i = 0; i < 3; i++) begin
      h = ~h; l = ~l; set_armed = ~set_armed; cfg = 5'b11111;
      tick();
      chk("reset_hold", trig, 1'b0);
    end
    cfg = 5'b00001; h = 1'b0; l = 1'b1; set_armed = 1'b0;
    tick();
    chk("reset_hold_cfg1", trig, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("force_first", trig, 1'b1);
    tick();
    chk("force_stay", trig, 1'b1);

    // 2. Positive edge capture, sticky, cleared by disarm.
    cfg = 5'b00010; set_armed = 1'b0; h = 1'b0; l = 1'b1;
    tick(); chk("pos_idle", trig, 1'b0);
    set_armed = 1'b1;
    tick(); chk("pos_armed_noedge", trig, 1'b0);
    h = 1'b1;
    tick(); chk("pos_edge", trig, 1'b1);
    h = 1'b0;
    tick(); chk("pos_sticky", trig, 1'b1);
    set_armed = 1'b0;
    tick(); chk("pos_disarm", trig, 1'b0);

    // 3. Negative edge ignored when disarmed, captured when armed.
    cfg = 5'b00100;
    tick(); chk("neg_idle", trig, 1'b0);
    l = 1'b0;
    tick(); chk("neg_unarmed", trig, 1'b0);
    l = 1'b1;
    tick(); chk("neg_unarmed_back", trig, 1'b0);
    set_armed = 1'b1;
    tick(); chk("neg_armed_noedge", trig, 1'b0);
    l = 1'b0;
    tick(); chk("neg_edge", trig, 1'b1);
    l = 1'b1;
    tick(); chk("neg_sticky", trig, 1'b1);
    set_armed = 1'b0;
    tick(); chk("neg_disarm", trig, 1'b0);

    // 4. Level terms follow inputs regardless of arming.
    cfg = 5'b01000; h = 1'b1;
    tick(); chk("hlvl_on", trig, 1'b1);
    h = 1'b0;
    tick(); chk("hlvl_off", trig, 1'b0);
    set_armed = 1'b1; h = 1'b1;
    tick(); chk("hlvl_on_armed", trig, 1'b1);
    h = 1'b0;
    tick(); chk("hlvl_off_armed", trig, 1'b0);
    cfg = 5'b10000; l = 1'b0;
    tick(); chk("llvl_on", trig, 1'b1);
    l = 1'b1;
    tick(); chk("llvl_off", trig, 1'b0);
    // Flag captured while its cfg bit was off is reported once enabled.
    cfg = 5'b00010;
    tick(); chk("late_enable_pos", trig, 1'b1);
    set_armed = 1'b0;
    tick(); chk("late_enable_clear", trig, 1'b0);

    // Edge on the clock arming rises is captured.
    set_armed = 1'b1; h = 1'b1;
    tick(); chk("arm_rise_edge", trig, 1'b1);
    set_armed = 1'b0; h = 1'b0;
    tick(); chk("arm_rise_clear", trig, 1'b0);

    // 6. Coincident edge and disarm: clear wins, no later phantom edge.
    set_armed = 1'b1;
    tick(); chk("clr_setup", trig, 1'b0);
    h = 1'b1; set_armed = 1'b0;
    tick(); chk("clr_wins", trig, 1'b0);
    set_armed = 1'b1;
    tick(); chk("clr_no_phantom", trig, 1'b0);

    // Mid-operation reset clears immediately; history reset makes high input an edge.
    h = 1'b0;
    tick();
    h = 1'b1;
    tick(); chk("pre_reset_set", trig, 1'b1);
    rst_n = 1'b0;
    #1; chk("async_reset", trig, 1'b0);
    tick();
    rst_n = 1'b1;
    tick(); chk("post_reset_edge", trig, 1'b1);
    cfg = 5'b00100; h = 1'b0; l = 1'b0;
    tick(); chk("post_reset_neg", trig, 1'b1);

    // 5. Mixed toggling against the reference model.
    rst_n = 1'b0; cfg = 5'b11110;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10000; k++) begin
      h         = (($time / 10) % 2) != 0;
      l         = (($time / 15) % 2) == 0;
      set_armed = (($time / 15) % 2) != 0;
      tick();
      chk("model_mix", trig, m_trig);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
